alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared combinational ALU. Accepts operation requests (operands plus ALU select) from two independent requesters over valid/ready handshakes. Issues one operation at a time to the ALU from registered operands and returns the registered result, tagged with the requester ID, on a single response port. Sits between the decode/execute front-ends and the single ALU instance, so that one ALU can be time-shared.

## Interface
- DATA_WIDTH, 32: operand and result width.
- SEL_WIDTH, 4: ALU select width.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending from requester 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands A, B.
- req0_sel / req1_sel  in  SEL_WIDTH  ALU operation code.
- alu_a, alu_b  out  DATA_WIDTH  operands driven to the ALU.
- alu_sel  out  SEL_WIDTH  select driven to the ALU.
- alu_out  in  DATA_WIDTH  ALU combinational result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  DATA_WIDTH  captured result.
- rsp_err  out  1  illegal-select flag (see Configuration).
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE
  - Grant is computed combinationally.
  - Exactly one of req0_ready/req1_ready is high, and only if its valid is high.
  - Acceptance occurs when valid && ready.
  - On acceptance: latch a, b, sel into alu_a/alu_b/alu_sel registers; latch the grant into rsp_id; go to EXEC.
- Round-robin grant
  - Pointer last_grant updates on every acceptance.
  - If both requesters are valid, grant the one not equal to last_grant.
  - If only one is valid, grant it regardless of last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- EXEC: one cycle. The ALU settles from the registered operands. Capture alu_out into rsp_data at the end of the cycle, then go to RESP.
- RESP
  - rsp_valid is high.
  - rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
- Both reqX_ready are low in EXEC and RESP.
- Requesters must hold valid and payload stable until ready. A valid that drops without a handshake is never granted.
- alu_a, alu_b and alu_sel hold their last issued values outside EXEC; they change only on acceptance.
- No arithmetic is performed in this block. rsp_data is the alu_out value exactly, DATA_WIDTH bits.

## Timing
- Reset values: state = IDLE; req0_ready, req1_ready = 0 while no valid is asserted; rsp_valid = 0; rsp_id = 0; rsp_data = 0; rsp_err = 0; busy = 0; alu_a = 0; alu_b = 0; alu_sel = 4'b0000 (ADD); last_grant = 1.
- Acceptance at edge N → EXEC during cycle N+1 → rsp_valid high from cycle N+2.
- Minimum latency is 2 cycles from acceptance to rsp_valid.
- With rsp_ready tied high:
  - the response handshake completes in cycle N+2 and the block returns to IDLE at N+3;
  - the next acceptance occurs at edge N+3;
  - peak throughput is therefore one operation per 3 cycles.
- Response backpressure: RESP holds indefinitely while rsp_ready is low, and both requesters stall.
- Reset mid-operation: an asynchronous assertion of rst_n returns everything to reset values immediately. An in-flight operation is dropped and no response is produced.
- rsp_ready asserted while rsp_valid is low has no effect.

## Configuration
- ALU_ARB_ILLEGAL_CHK_EN defined:
  - Legal selects are 0000–1001 and 1111.
  - An accepted request with any other sel is still handshaked and still advances last_grant.
  - alu_sel is not updated for it.
  - It passes through EXEC, then responds with rsp_data = 0 and rsp_err = 1.
  - Legal requests respond with rsp_err = 0.
- ALU_ARB_ILLEGAL_CHK_EN undefined:
  - All selects are forwarded unchanged.
  - rsp_err is tied to 0.
  - For undefined codes, rsp_data is whatever alu_out presents.

## Test plan
- Single request: req0 a=5, b=3, sel=0001 (SUB), rsp_ready=1 → rsp_valid at acceptance+2, rsp_data=2, rsp_id=0.
- Tie after reset: req0 and req1 both valid at once → req0 granted first, req1 granted at edge +3; rsp_id sequence 0, 1.
- Round-robin fairness: both requesters held valid continuously for 6 operations → grants alternate 0, 1, 0, 1, 0, 1.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_data and rsp_id stable, both reqX_ready low, busy=1; the result is delivered when rsp_ready rises.
- Reset mid-operation: drop rst_n during EXEC → all outputs return to reset values immediately; after release, no stale response appears.
- Illegal select with ALU_ARB_ILLEGAL_CHK_EN: req1 sel=1010 → rsp_err=1, rsp_data=0, alu_sel unchanged. Without the macro → rsp_err=0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Two-requester round-robin arbiter/sequencer that time-shares one
//             external combinational ALU. Operands are registered on accept,
//             the ALU result is captured after one EXEC cycle, and the result
//             is returned tagged with the requester ID.
//  Options  : ALU_ARB_ILLEGAL_CHK_EN - flag selects outside 0..9 and all-ones
//             as illegal (rsp_err=1, rsp_data=0, alu_sel left untouched).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [SEL_WIDTH-1:0]  req0_sel,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [SEL_WIDTH-1:0]  req1_sel,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [SEL_WIDTH-1:0]  alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q,      alu_b_d;
    logic [SEL_WIDTH-1:0]  alu_sel_q,    alu_sel_d;
    logic                  rsp_id_q,     rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic                  rsp_err_q,    rsp_err_d;
    logic                  err_pend_q,   err_pend_d;

    logic                  grant;
    logic                  accept;
    logic [DATA_WIDTH-1:0] mux_a;
    logic [DATA_WIDTH-1:0] mux_b;
    logic [SEL_WIDTH-1:0]  mux_sel;
    logic                  sel_illegal;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        accept     = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = (state_q == IDLE) && req0_valid && !grant;
        req1_ready = (state_q == IDLE) && req1_valid &&  grant;
        mux_a      = grant ? req1_a   : req0_a;
        mux_b      = grant ? req1_b   : req0_b;
        mux_sel    = grant ? req1_sel : req0_sel;
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    // Legal codes are 0..9 plus the all-ones code.
    always_comb begin
        sel_illegal = (mux_sel > SEL_WIDTH'(9)) && (mux_sel != {SEL_WIDTH{1'b1}});
    end
`else
    assign sel_illegal = 1'b0;
`endif

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            err_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            err_pend_q   <= err_pend_d;
        end
    end

    // Next-state logic: accept in IDLE, capture ALU result in EXEC, hold in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        err_pend_d   = err_pend_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    alu_a_d      = mux_a;
                    alu_b_d      = mux_b;
                    if (!sel_illegal) begin
                        alu_sel_d = mux_sel;
                    end
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    err_pend_d   = sel_illegal;
                end
            end
            EXEC: begin
                rsp_data_d = err_pend_q ? '0 : alu_out;
                rsp_err_d  = err_pend_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter with a behavioural ALU and
//             a transaction-level reference model of grant order and results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [SW-1:0] req0_sel = '0, req1_sel = '0;
    logic [DW-1:0] alu_a, alu_b, alu_out, rsp_data;
    logic [SW-1:0] alu_sel;
    logic          rsp_valid, rsp_id, rsp_err, busy;
    logic          rsp_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_last;
    logic [DW-1:0] m_alu_a, m_alu_b;
    logic [SW-1:0] m_alu_sel;
    logic          pend_v [2];
    logic [DW-1:0] pend_a [2];
    logic [DW-1:0] pend_b [2];
    logic [SW-1:0] pend_s [2];

    alu_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [SW-1:0] s);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return DW'($signed(a) >>> b[4:0]);
            4'd8:    return {31'b0, $signed(a) < $signed(b)};
            4'd9:    return {31'b0, a < b};
            4'd15:   return b;
            default: return ~(a ^ b) + 32'h1234;
        endcase
    endfunction

    // Environment ALU: purely combinational on the arbiter's registered operands.
    assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

    function automatic logic is_illegal(input logic [SW-1:0] s);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        return (s > 4'd9) && (s != 4'hF);
`else
        return (s != s);
`endif
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        req0_valid = pend_v[0]; req0_a = pend_a[0]; req0_b = pend_b[0]; req0_sel = pend_s[0];
        req1_valid = pend_v[1]; req1_a = pend_a[1]; req1_b = pend_b[1]; req1_sel = pend_s[1];
    endtask

    task automatic new_req(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [SW-1:0] s);
        pend_v[r] = 1'b1; pend_a[r] = a; pend_b[r] = b; pend_s[r] = s;
    endtask

    task automatic model_reset();
        m_last = 1'b1; m_alu_a = '0; m_alu_b = '0; m_alu_sel = '0;
    endtask

    task automatic chk_reset_values(input string p);
        chk({p, "_busy"},      busy, 0);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_rsp_id"},    rsp_id, 0);
        chk({p, "_rsp_data"},  rsp_data, 0);
        chk({p, "_rsp_err"},   rsp_err, 0);
        chk({p, "_alu_a"},     alu_a, 0);
        chk({p, "_alu_b"},     alu_b, 0);
        chk({p, "_alu_sel"},   alu_sel, 0);
        chk({p, "_req0_rdy"},  req0_ready, 0);
        chk({p, "_req1_rdy"},  req1_ready, 0);
    endtask

    // One full transaction, entered just after a negedge with the block idle.
    task automatic step(input int hold);
        logic          g;
        int            gi;
        logic          e_err;
        logic [DW-1:0] e_data;
        drive_reqs();
        #1;
        if (pend_v[0] && pend_v[1]) g = ~m_last;
        else                        g = pend_v[1];
        gi = int'(g);
        chk("idle_busy",  busy, 0);
        chk("idle_rvld",  rsp_valid, 0);
        chk("req0_ready", req0_ready, pend_v[0] && !g);
        chk("req1_ready", req1_ready, pend_v[1] &&  g);
        e_err  = is_illegal(pend_s[gi]);
        e_data = e_err ? '0 : alu_fn(pend_a[gi], pend_b[gi], pend_s[gi]);
        m_last  = g;
        m_alu_a = pend_a[gi];
        m_alu_b = pend_b[gi];
        if (!e_err) m_alu_sel = pend_s[gi];
        @(posedge clk);
        pend_v[gi] = 1'b0;
        @(negedge clk);
        drive_reqs();
        #1;
        chk("exec_busy",    busy, 1);
        chk("exec_rvld",    rsp_valid, 0);
        chk("exec_rdy",     {req0_ready, req1_ready}, 0);
        chk("exec_alu_a",   alu_a, m_alu_a);
        chk("exec_alu_b",   alu_b, m_alu_b);
        chk("exec_alu_sel", alu_sel, m_alu_sel);
        @(negedge clk);
        #1;
        chk("resp_rvld", rsp_valid, 1);
        chk("resp_id",   rsp_id, g);
        chk("resp_data", rsp_data, e_data);
        chk("resp_err",  rsp_err, e_err);
        chk("resp_rdy",  {req0_ready, req1_ready}, 0);
        rsp_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk("bp_rvld", rsp_valid, 1);
            chk("bp_id",   rsp_id, g);
            chk("bp_data", rsp_data, e_data);
            chk("bp_busy", busy, 1);
            chk("bp_rdy",  {req0_ready, req1_ready}, 0);
            if (i == hold - 1) rsp_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 2; r++) begin
            pend_v[r] = 1'b0; pend_a[r] = '0; pend_b[r] = '0; pend_s[r] = '0;
        end
        model_reset();
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: 5 - 3 from requester 0
        new_req(0, 32'd5, 32'd3, 4'b0001);
        step(0);

        // Reset during EXEC drops the operation
        new_req(1, $urandom, $urandom, 4'd0);
        drive_reqs();
        @(posedge clk);
        pend_v[1] = 1'b0;
        @(negedge clk);
        drive_reqs();
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_rvld", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        // Tie after reset: requester 0 then 1
        new_req(0, $urandom, $urandom, 4'd2);
        new_req(1, $urandom, $urandom, 4'd3);
        step(0);
        step(0);

        // Fairness: both requesters continuously valid for six operations
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pend_v[r]) new_req(r, $urandom, $urandom, 4'($urandom_range(0, 9)));
            step(0);
        end
        while (pend_v[0] || pend_v[1]) step(0);

        // Response backpressure for five cycles
        new_req(0, $urandom, $urandom, 4'd4);
        step(5);

        // Illegal select from requester 1 after a legal op
        new_req(0, $urandom, $urandom, 4'd2);
        step(0);
        new_req(1, $urandom, $urandom, 4'b1010);
        step(0);

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pend_v[r] && ($urandom_range(0, 1) == 1))
                    new_req(r, $urandom, $urandom, 4'($urandom_range(0, 15)));
            if (!pend_v[0] && !pend_v[1])
                new_req(int'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            step(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
